// File: rtl/counter_16bit.sv
// 16-bit up-counter with clear/load, one-shot or free-running wrap, and IDLE/RUN/DONE FSM.
// Optional `COUNTER_MODULO_EN adds a programmable terminal count via the limit input.

module incrementer_16bit (
    input  logic [15:0] a,
    output logic [15:0] s,
    output logic [15:0] c
);

    // Ripple half-adder chain with an implicit carry-in of one; c[15] is set only for a == 16'hFFFF.
    always_comb begin
        s    = 16'h0000;
        c    = 16'h0000;
        s[0] = ~a[0];
        c[0] = a[0];
        for (int i = 1; i < 16; i++) begin
            s[i] = a[i] ^ c[i-1];
            c[i] = a[i] & c[i-1];
        end
    end

endmodule

module counter_16bit #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        oneshot,
    input  logic [15:0] limit,
    output logic [15:0] q,
    output logic        tc,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        tc_q;
    logic        tc_d;
    logic        ovf_q;
    logic        ovf_d;

    logic [15:0] inc_s;
    logic [15:0] carry_s;
    logic        terminal_s;
    logic        unused_carry_low_s;

    incrementer_16bit u_inc (
        .a (q_q),
        .s (inc_s),
        .c (carry_s)
    );

    assign unused_carry_low_s = ^carry_s[14:0];

`ifdef COUNTER_MODULO_EN
    // Terminal at the programmed limit, with the carry still catching 16'hFFFF above it.
    always_comb begin
        terminal_s = carry_s[15] | (q_q == limit);
    end
`else
    logic unused_limit_s;

    assign unused_limit_s = ^limit;

    // Only the all-ones value terminates the count.
    always_comb begin
        terminal_s = carry_s[15];
    end
`endif

    // Next-state decode: clr beats load beats counting; tc defaults low so it is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            q_d     = RESET_VAL;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
        end else if (load) begin
            q_d     = load_val;
            state_d = en ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    // IDLE leaves on the first enabled edge, which also counts.
                    if (en) begin
                        if (terminal_s) begin
                            tc_d  = 1'b1;
                            ovf_d = 1'b1;
                            if (oneshot) begin
                                state_d = S_DONE;
                            end else begin
                                q_d     = 16'h0000;
                                state_d = S_RUN;
                            end
                        end else begin
                            q_d     = inc_s;
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= RESET_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_counter_16bit.sv
// Directed self-checking bench for counter_16bit; the modulo scenario follows `COUNTER_MODULO_EN.

module tb_counter_16bit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        oneshot;
    logic [15:0] limit;
    logic [15:0] q;
    logic        tc;
    logic        ovf;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    counter_16bit #(.RESET_VAL(16'h0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .oneshot  (oneshot),
        .limit    (limit),
        .q        (q),
        .tc       (tc),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout: {q, tc, ovf, busy, done}
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = 16'h0000; oneshot = 1'b0; limit = 16'h0000;
        #12;
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0000 0 0 0 0", q, tc, ovf, busy, done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        checks++;
        if (q !== 16'h0000) begin
            failures++;
            $display("FAIL count_start: got q=%h want 0000", q);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({q, tc, ovf, busy, done} !== {i[15:0], 1'b0, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL count_%0d: got q=%h tc=%b ovf=%b busy=%b done=%b, want q=%h tc=0 ovf=0 busy=1 done=0",
                         i, q, tc, ovf, busy, done, i[15:0]);
            end
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        tick();
        tick();
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0005, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL hold: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0005 0 0 1 0", q, tc, ovf, busy, done);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_q  [4];
        logic        exp_tc [4];
        exp_q[0] = 16'hFFFE; exp_tc[0] = 1'b0;
        exp_q[1] = 16'hFFFF; exp_tc[1] = 1'b0;
        exp_q[2] = 16'h0000; exp_tc[2] = 1'b1;
        exp_q[3] = 16'h0001; exp_tc[3] = 1'b0;
        load_val = 16'hFFFE; load = 1'b1; en = 1'b1; oneshot = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 1'b0;
            checks++;
            if ({q, tc, ovf, busy} !== {exp_q[i], exp_tc[i], (i >= 2) ? 1'b1 : 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL wrap_%0d: got q=%h tc=%b ovf=%b busy=%b, want q=%h tc=%b ovf=%b busy=1",
                         i, q, tc, ovf, busy, exp_q[i], exp_tc[i], (i >= 2) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_clr_load();
        load_val = 16'h0010; load = 1'b1; en = 1'b1;
        tick();
        checks++;
        if ({q, busy, ovf} !== {16'h0010, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL load_0010: got q=%h busy=%b ovf=%b, want 0010 1 1", q, busy, ovf);
        end
        clr = 1'b1; load_val = 16'h1234;
        tick();
        clr = 1'b0; load = 1'b0; en = 1'b0;
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clr_over_load: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0000 0 0 0 0", q, tc, ovf, busy, done);
        end
    endtask

    task automatic test_oneshot();
        load_val = 16'hFFFD; load = 1'b1; en = 1'b1; oneshot = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL oneshot_pre: got q=%h tc=%b ovf=%b busy=%b done=%b, want FFFF 0 0 1 0", q, tc, ovf, busy, done);
        end
        tick();
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL oneshot_tc: got q=%h tc=%b ovf=%b busy=%b done=%b, want FFFF 1 1 0 1", q, tc, ovf, busy, done);
        end
        tick();
        en = 1'b0;
        tick();
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL oneshot_done_hold: got q=%h tc=%b ovf=%b busy=%b done=%b, want FFFF 0 1 0 1", q, tc, ovf, busy, done);
        end
        load_val = 16'h0005; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0005, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL load_from_done: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0005 0 1 0 0", q, tc, ovf, busy, done);
        end
        oneshot = 1'b0;
    endtask

    task automatic test_modulo();
        clr = 1'b1;
        tick();
        clr = 1'b0;
`ifdef COUNTER_MODULO_EN
        limit = 16'h0003; oneshot = 1'b1; en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({q, tc, busy} !== {i[15:0], 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL modulo_%0d: got q=%h tc=%b busy=%b, want q=%h tc=0 busy=1", i, q, tc, busy, i[15:0]);
            end
        end
        tick();
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0003, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL modulo_tc: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0003 1 1 0 1", q, tc, ovf, busy, done);
        end
        en = 1'b0; tick(); en = 1'b1; tick();
        checks++;
        if ({q, tc, busy, done} !== {16'h0003, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL modulo_done_hold: got q=%h tc=%b busy=%b done=%b, want 0003 0 0 1", q, tc, busy, done);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        limit = 16'h0000; oneshot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({q, tc, ovf, busy} !== {16'h0000, 1'b1, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL back_to_back_%0d: got q=%h tc=%b ovf=%b busy=%b, want 0000 1 1 1", i, q, tc, ovf, busy);
            end
        end
`else
        limit = 16'h0003; oneshot = 1'b1; en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({q, tc, ovf, busy, done} !== {i[15:0], 1'b0, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL limit_ignored_%0d: got q=%h tc=%b ovf=%b busy=%b done=%b, want q=%h 0 0 1 0",
                         i, q, tc, ovf, busy, done, i[15:0]);
            end
        end
`endif
        en = 1'b0; oneshot = 1'b0; limit = 16'h0000;
    endtask

    task automatic test_async_reset();
        load_val = 16'h00A5; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({q, busy} !== {16'h00A5, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset: got q=%h busy=%b, want 00A5 1", q, busy);
        end
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0000 0 0 0 0", q, tc, ovf, busy, done);
        end
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        checks++;
        if ({q, tc, ovf, busy, done} !== {16'h0001, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_first_edge: got q=%h tc=%b ovf=%b busy=%b done=%b, want 0001 0 0 1 0", q, tc, ovf, busy, done);
        end
        en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_count();
        test_hold();
        test_wrap();
        test_clr_load();
        test_oneshot();
        test_modulo();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
